// File: rtl/zone_stat_grid.sv
// Crops the active picture into an H_ZONES x V_ZONES grid, computes a per-zone max/mean/blend
// statistic and stores it in a double-buffered zone RAM read back through an address/data port.
module zone_stat_grid #(
    parameter int DW      = 8,
    parameter int H_ZONES = 24,
    parameter int V_ZONES = 15,
    parameter int ZONE_W  = 53,
    parameter int ZONE_H  = 53,
    parameter int X_OFF   = 4,
    parameter int Y_OFF   = 3,
    parameter int RSH     = 20,
    localparam int ZA     = $clog2(H_ZONES * V_ZONES)
) (
    input  logic          i_pix_clk,
    input  logic          rst_n,
    input  logic          i_vsync,
    input  logic          data_de,
    input  logic [10:0]   pix_x,
    input  logic [10:0]   pix_y,
    input  logic [DW-1:0] data_gray,
    input  logic [1:0]    mode,
    input  logic          rd_en,
    input  logic [ZA-1:0] rd_addr,
    output logic [DW-1:0] rd_data,
    output logic          rd_valid,
    output logic          frame_done,
    output logic          err_short,
    output logic          stats_valid
);

    localparam int NZ    = H_ZONES * V_ZONES;
    localparam int ZPIX  = ZONE_W * ZONE_H;
    localparam int SW    = DW + $clog2(ZPIX);
    localparam int RECIP = ((1 << RSH) + ZPIX / 2) / ZPIX;
    localparam int RW    = $clog2(RECIP + 1);
    localparam int PW    = SW + RW;
    localparam int PW1   = PW + 1;
    localparam int DW1   = DW + 1;
    localparam int ZA1   = ZA + 1;
    localparam int MAXV  = (1 << DW) - 1;
    localparam int PXW   = (ZONE_W  > 1) ? $clog2(ZONE_W)  : 1;
    localparam int HZW   = (H_ZONES > 1) ? $clog2(H_ZONES) : 1;
    localparam int PYW   = (ZONE_H  > 1) ? $clog2(ZONE_H)  : 1;
    localparam int VZW   = (V_ZONES > 1) ? $clog2(V_ZONES + 1) : 1;
    localparam logic [11:0] X_LO = 12'(X_OFF);
    localparam logic [11:0] X_HI = 12'(X_OFF + H_ZONES * ZONE_W);
    localparam logic [11:0] Y_LO = 12'(Y_OFF);
    localparam logic [11:0] Y_HI = 12'(Y_OFF + V_ZONES * ZONE_H);

    logic [PXW-1:0] cnt_px;
    logic [HZW-1:0] cnt_hz;
    logic [PYW-1:0] cnt_py;
    logic [VZW-1:0] cnt_vz;
    logic [DW-1:0]  acc_max [H_ZONES];
    logic [SW-1:0]  acc_sum [H_ZONES];
    logic [DW-1:0]  zone_ram [2][NZ];

    logic [1:0]     mode_q;
    logic           bank;
    logic           frame_active;
    logic           in_win, take, end_px, end_hz, end_py, first, close;
    logic [DW-1:0]  cur_max, fin_max;
    logic [SW-1:0]  cur_sum, fin_sum;
    logic [ZA-1:0]  zone_addr;

    logic           s1_valid;
    logic [DW-1:0]  s1_max;
    logic [PW-1:0]  s1_prod;
    logic [ZA-1:0]  s1_addr;
    logic           s2_valid, s2_last;
    logic [DW-1:0]  s2_result;
    logic [ZA-1:0]  s2_addr;

    logic [PW1-1:0] mean_rnd, mean_shift;
    logic [DW-1:0]  mean, blend, result;

    // Counters track counted pixels only, so zone position never depends on pix_x/pix_y values.
    always_comb begin
        in_win    = data_de
                    && ({1'b0, pix_x} >= X_LO) && ({1'b0, pix_x} < X_HI)
                    && ({1'b0, pix_y} >= Y_LO) && ({1'b0, pix_y} < Y_HI);
        take      = in_win && !i_vsync;
        end_px    = (cnt_px == PXW'(ZONE_W - 1));
        end_hz    = (cnt_hz == HZW'(H_ZONES - 1));
        end_py    = (cnt_py == PYW'(ZONE_H - 1));
        first     = (cnt_px == '0) && (cnt_py == '0);
        close     = end_px && end_py;
        cur_max   = acc_max[cnt_hz];
        cur_sum   = acc_sum[cnt_hz];
        fin_max   = (first || (data_gray > cur_max)) ? data_gray : cur_max;
        fin_sum   = first ? SW'(data_gray) : cur_sum + SW'(data_gray);
        zone_addr = ZA'(int'(cnt_vz) * H_ZONES + int'(cnt_hz));
    end

    always_comb begin
        mean_rnd   = {1'b0, s1_prod} + PW1'(1 << (RSH - 1));
        mean_shift = mean_rnd >> RSH;
        mean       = (mean_shift > PW1'(MAXV)) ? {DW{1'b1}} : mean_shift[DW-1:0];
        blend      = DW'(({1'b0, s1_max} + {1'b0, mean} + DW1'(1)) >> 1);
        case (mode_q)
            2'd1:    result = mean;
            2'd2:    result = blend;
            default: result = s1_max;
        endcase
    end

    always_ff @(posedge i_pix_clk) begin
        if (!rst_n) begin
            cnt_px       <= '0;
            cnt_hz       <= '0;
            cnt_py       <= '0;
            cnt_vz       <= '0;
            mode_q       <= '0;
            bank         <= 1'b0;
            frame_active <= 1'b0;
            stats_valid  <= 1'b0;
            frame_done   <= 1'b0;
            err_short    <= 1'b0;
            rd_data      <= '0;
            rd_valid     <= 1'b0;
            s1_valid     <= 1'b0;
            s1_max       <= '0;
            s1_prod      <= '0;
            s1_addr      <= '0;
            s2_valid     <= 1'b0;
            s2_last      <= 1'b0;
            s2_result    <= '0;
            s2_addr      <= '0;
            for (int i = 0; i < H_ZONES; i++) begin
                acc_max[i] <= '0;
                acc_sum[i] <= '0;
            end
        end else begin
            frame_done <= 1'b0;
            err_short  <= 1'b0;
            s1_valid   <= take && close;
            s1_max     <= fin_max;
            s1_prod    <= PW'(fin_sum) * PW'(RECIP);
            s1_addr    <= zone_addr;
            s2_valid   <= s1_valid && !i_vsync;
            s2_last    <= (s1_addr == ZA'(NZ - 1));
            s2_result  <= result;
            s2_addr    <= s1_addr;
            rd_valid   <= rd_en;
            if (rd_en)
                rd_data <= (stats_valid && ({1'b0, rd_addr} < ZA1'(NZ))) ? zone_ram[bank][rd_addr] : '0;

            if (i_vsync) begin
                cnt_px       <= '0;
                cnt_hz       <= '0;
                cnt_py       <= '0;
                cnt_vz       <= '0;
                mode_q       <= mode;
                err_short    <= frame_active;
                frame_active <= 1'b0;
                for (int i = 0; i < H_ZONES; i++) begin
                    acc_max[i] <= '0;
                    acc_sum[i] <= '0;
                end
            end else begin
                if (take) begin
                    frame_active    <= 1'b1;
                    acc_max[cnt_hz] <= fin_max;
                    acc_sum[cnt_hz] <= fin_sum;
                    if (end_px) begin
                        cnt_px <= '0;
                        if (end_hz) begin
                            cnt_hz <= '0;
                            if (end_py) begin
                                cnt_py <= '0;
                                cnt_vz <= cnt_vz + 1'b1;
                            end else begin
                                cnt_py <= cnt_py + 1'b1;
                            end
                        end else begin
                            cnt_hz <= cnt_hz + 1'b1;
                        end
                    end else begin
                        cnt_px <= cnt_px + 1'b1;
                    end
                end
                // Last zone written this cycle: swap banks so readers see the new frame.
                if (s2_valid && s2_last) begin
                    bank         <= ~bank;
                    frame_done   <= 1'b1;
                    stats_valid  <= 1'b1;
                    frame_active <= 1'b0;
                end
            end
        end
    end

    // A vsync in the same cycle cancels the write, matching the suppressed bank swap.
    always_ff @(posedge i_pix_clk) begin
        if (rst_n && s2_valid && !i_vsync)
            zone_ram[~bank][s2_addr] <= s2_result;
    end

endmodule

// File: doc/zone_stat_grid.md
Name: zone_stat_grid

Overview:
Parametrised successor to the fixed 24x15 max-zone block for the MiniLED local-dimming path. It crops the active picture and tiles it into an H_ZONES x V_ZONES grid. Per zone it computes one of three statistics: max, mean, or max/mean blend. Results land in a double-buffered zone RAM, which the backlight driver reads through an address/data port after a frame_done pulse, so there is no wide flat bus.

Parameters:
DW, 8, pixel and result width
H_ZONES, 24, zones per row
V_ZONES, 15, zone rows
ZONE_W, 53, pixels per zone horizontally
ZONE_H, 53, lines per zone vertically
X_OFF, 4, first counted pixel column
Y_OFF, 3, first counted line
RSH, 20, reciprocal shift for mean; RECIP = round(2^RSH/(ZONE_W*ZONE_H)) is a localparam (373 at defaults)

Ports:
i_pix_clk  in  1  pixel clock, single clock domain
rst_n  in  1  synchronous reset, active-low
i_vsync  in  1  one-cycle frame-start pulse
data_de  in  1  pixel valid
pix_x  in  11  pixel column
pix_y  in  11  pixel line
data_gray  in  DW  pixel gray value
mode  in  2  0=max, 1=mean, 2=blend, 3=max (reserved); sampled on i_vsync
rd_en  in  1  zone read request
rd_addr  in  ZA  zone index = vz*H_ZONES+hz; ZA=clog2(H_ZONES*V_ZONES)
rd_data  out  DW  zone result
rd_valid  out  1  rd_data valid
frame_done  out  1  one-cycle pulse; new results are readable
err_short  out  1  one-cycle pulse; frame ended before the last zone completed
stats_valid  out  1  high once any frame has completed

Behaviour:
- Reset: rd_data=0, rd_valid=0, frame_done=0, err_short=0, stats_valid=0; all counters, accumulators and the bank pointer cleared; mode_q=0. RAM contents are not cleared; reads return 0 until stats_valid=1.
- Window: a pixel counts when data_de=1, X_OFF<=pix_x<X_OFF+H_ZONES*ZONE_W and Y_OFF<=pix_y<Y_OFF+V_ZONES*ZONE_H. All other pixels are ignored.
- Counters: cnt_px (0..ZONE_W-1), cnt_hz, cnt_py (0..ZONE_H-1), cnt_vz.
  - They advance only on counted pixels.
  - cnt_px/cnt_hz wrap at end of row; cnt_py increments at the last pixel of a line; cnt_vz increments when cnt_py wraps.
  - i_vsync clears all counters and accumulators.
  - i_vsync takes priority over a simultaneous pixel, and that pixel is dropped.
- Accumulators: per-column arrays acc_max[H_ZONES] (DW bits) and acc_sum[H_ZONES] (DW+clog2(ZONE_W*ZONE_H) bits).
  - First pixel of a zone (cnt_px=0, cnt_py=0) loads the pixel value.
  - Other pixels update max and add to sum.
- Zone close: on the zone's last pixel (cnt_px=ZONE_W-1, cnt_py=ZONE_H-1), final max/sum include that pixel.
  - Stage 1 registers max and sum*RECIP.
  - Stage 2 forms mean = (prod + 2^(RSH-1)) >> RSH, clamped to 2^DW-1.
  - Stage 2 selects the result by mode_q: max, mean, or blend = (max+mean+1)>>1.
  - Stage 2 writes the result to the back bank at cnt_vz*H_ZONES+cnt_hz.
  - Write occurs 2 cycles after the closing pixel.
- Frame completion: when zone H_ZONES*V_ZONES-1 is written:
  - the bank pointer toggles in the same cycle;
  - frame_done pulses the next cycle;
  - stats_valid is set.
- Short frame: i_vsync arriving after at least one counted pixel but before completion pulses err_short. There is no swap; the partial back bank is discarded and the front bank keeps the previous frame. If the closing pipeline is in flight, its write is suppressed.
- Readout: rd_en samples rd_addr.
  - rd_valid and rd_data appear 1 cycle later and come from the front bank.
  - An address >= H_ZONES*V_ZONES, or stats_valid=0, returns 0 with rd_valid=1.
  - If a read coincides with the swap, it returns the pre-swap front bank.
  - Back-to-back reads give 1 result per cycle.
- Reset mid-frame returns to the reset state; the next i_vsync starts cleanly.

Test Plan:
- Defaults, mode=0, uniform 0x40 frame -> one frame_done; all 360 reads = 0x40; stats_valid=1; err_short=0.
- mode=0, black frame with 0xFF at pix (X_OFF+5*53+10, Y_OFF+2*53+7) -> addr 53 = 0xFF; all other addresses = 0x00.
- mode=1, uniform 0x80 frame -> all reads 0x80. Then uniform 0xFF frame -> 0xFF, with no overflow past the clamp.
- mode=2, black frame plus one 0xFF pixel in zone 0 -> addr 0 = 0x80, others 0. mode changed mid-frame -> no effect until the next i_vsync.
- Margins: 0xFF at pix_x=2 and at pix_y=V_ACTIVE-1, rest 0 -> all zones 0. rd_addr=360 -> rd_data=0, rd_valid=1.
- Short frame: full frame of 0x40, then a frame of 0x90 cut by i_vsync after 10 zone rows -> err_short pulse, no frame_done, reads still 0x40. Reset asserted mid-frame -> outputs 0, stats_valid=0.
